id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Decode-side pipeline stage of the MIPS core. It takes the instruction word held in IF/ID and decodes opcode/funct into the main control bundle. It registers the control bundle, immediate and register indices into the ID/EX boundary, edge-aligned with the register file's registered read data. It also detects load-use hazards and emits the stall that freezes the PC and IF/ID while it inserts a bubble.

## Interface
Parameters:
- LEN, 32, datapath/instruction width
- NB_ADDR, 5, register index width
- NB_ALUOP, 2, ALUOp width

Ports:
- i_clk  in  1  pipeline clock; all state updates on posedge
- i_rst  in  1  synchronous, active-high reset
- i_enable  in  1  pipeline enable (debug step); 0 freezes all state
- i_flush  in  1  branch/jump taken; squash the instruction being decoded
- i_instruction  in  LEN  IF/ID instruction word
- o_stall  out  1  load-use stall to PC and IF/ID (combinational)
- o_rs, o_rt, o_rd  out  NB_ADDR each  registered register indices
- o_imm_ext  out  LEN  registered extended immediate
- o_shamt  out  5  registered shift amount
- o_funct  out  6  registered funct field
- o_opcode  out  6  registered opcode (immediate ALU control)
- o_RegDst, o_ALUSrc, o_MemRead, o_MemWrite, o_MemtoReg, o_RegWrite, o_Branch, o_BranchNE, o_Jump  out  1 each  registered control
- o_ALUOp  out  NB_ALUOP  registered ALU op class

## Operation
- Decode is combinational from i_instruction[31:26].
- R-type 000000: RegDst=1, RegWrite=1, ALUOp=10.
- LW 100011: ALUSrc=1, MemRead=1, MemtoReg=1, RegWrite=1, ALUOp=00.
- SW 101011: ALUSrc=1, MemWrite=1, ALUOp=00.
- BEQ 000100: Branch=1, ALUOp=01.
- BNE 000101: BranchNE=1, ALUOp=01.
- ADDI 001000 and SLTI 001010: ALUSrc=1, RegWrite=1, ALUOp=11 (add/slt selected by o_opcode).
- ANDI 001100, ORI 001101, XORI 001110, LUI 001111: ALUSrc=1, RegWrite=1, ALUOp=11.
- J 000010: Jump=1.
- Any other opcode decodes as a NOP: all control bits 0.
- Immediate extension:
  - ANDI/ORI/XORI zero-extend [15:0].
  - LUI outputs {imm,16'h0}.
  - All other opcodes sign-extend.
- Hazard detection: o_stall = i_enable & o_MemRead & (o_rt != 0) & (o_rt == instr[25:21] | o_rt == instr[20:16]).
  - The comparison is conservative: rt is compared for every opcode.
- Bubble: all control outputs load 0; index, immediate, funct and opcode fields load normally (don't-care).

## Timing
- Reset (i_rst=1 at posedge): every output register is 0, so o_stall=0.
- Update priority per posedge:
  - i_rst, then
  - !i_enable (hold every register), then
  - i_flush (bubble), then
  - o_stall (bubble), then
  - normal load.
- Latency: an instruction present at IF/ID before edge N appears on the outputs after edge N. This is the same edge on which the register file registers its read data.
- Load-use stall lasts exactly 1 cycle. After the bubble, o_MemRead=0, so o_stall deasserts combinationally.
- Flush and stall in the same cycle: the bubble is inserted. o_stall may still assert that cycle; the upstream flush overrides the IF/ID hold.
- i_enable=0 forces o_stall=0 and freezes all outputs. Resuming continues exactly where it stopped.
- Reset asserted mid-stall clears state; no stall on the next cycle.

## Structure
- Shared package (mips_pkg): opcode localparams, ALUOp encodings, field bit positions, NOP control bundle constant.
- One natural sub-module: control_unit (combinational opcode-to-control decoder plus immediate extender).
- This block instantiates control_unit and holds the hazard compare and the ID/EX registers.

## Test plan
- Reset with i_instruction=ADDI: hold i_rst=1 for 2 cycles -> all outputs 0 and o_stall=0. Release -> after next edge, RegWrite=1, ALUSrc=1, ALUOp=11.
- Sign extension: LW $2,0xFFFC($1) -> o_imm_ext=32'hFFFF_FFFC, MemRead=1, o_rt=2.
- Zero extension: ORI with imm 0x8000 -> o_imm_ext=32'h0000_8000.
- Load-use hazard: LW $2 followed by ADD $3,$2,$4 -> o_stall=1 for exactly 1 cycle and ADD's slot carries all-zero control. Next edge latches ADD: RegDst=1, ALUOp=10.
- LW $0 followed by ADD $3,$0,$4 -> no stall.
- i_flush=1 with BEQ at IF/ID -> outputs all-zero control after the edge. i_flush=1 coinciding with a load-use stall -> bubble, no double stall.
- i_enable=0 for 3 cycles with changing i_instruction -> outputs unchanged and o_stall=0. Re-enable -> next edge loads the current instruction. Undefined opcode 111111 -> all control 0.

Source files
------------

// File: rtl/mips_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mips_pkg                                                                   |
// | Opcodes, ALUOp classes, instruction field positions and control bundle.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_IMM    = 2'b11;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int RD_MSB     = 15;
    localparam int RD_LSB     = 11;
    localparam int SHAMT_MSB  = 10;
    localparam int SHAMT_LSB  = 6;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;

    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       branch;
        logic       branch_ne;
        logic       jump;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage
`default_nettype wire

// File: rtl/id_ex_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | id_ex_stage_if                                                             |
// | IF/ID-side inputs and ID/EX-side outputs of the decode stage.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface id_ex_stage_if #(
    parameter int LEN      = 32,
    parameter int NB_ADDR  = 5,
    parameter int NB_ALUOP = 2
);
    logic                i_enable;
    logic                i_flush;
    logic [LEN-1:0]      i_instruction;
    logic                o_stall;
    logic [NB_ADDR-1:0]  o_rs;
    logic [NB_ADDR-1:0]  o_rt;
    logic [NB_ADDR-1:0]  o_rd;
    logic [LEN-1:0]      o_imm_ext;
    logic [4:0]          o_shamt;
    logic [5:0]          o_funct;
    logic [5:0]          o_opcode;
    logic                o_RegDst;
    logic                o_ALUSrc;
    logic                o_MemRead;
    logic                o_MemWrite;
    logic                o_MemtoReg;
    logic                o_RegWrite;
    logic                o_Branch;
    logic                o_BranchNE;
    logic                o_Jump;
    logic [NB_ALUOP-1:0] o_ALUOp;

    modport master (
        output i_enable, i_flush, i_instruction,
        input  o_stall, o_rs, o_rt, o_rd, o_imm_ext, o_shamt, o_funct, o_opcode,
               o_RegDst, o_ALUSrc, o_MemRead, o_MemWrite, o_MemtoReg, o_RegWrite,
               o_Branch, o_BranchNE, o_Jump, o_ALUOp
    );

    modport slave (
        input  i_enable, i_flush, i_instruction,
        output o_stall, o_rs, o_rt, o_rd, o_imm_ext, o_shamt, o_funct, o_opcode,
               o_RegDst, o_ALUSrc, o_MemRead, o_MemWrite, o_MemtoReg, o_RegWrite,
               o_Branch, o_BranchNE, o_Jump, o_ALUOp
    );
endinterface
`default_nettype wire

// File: rtl/id_ex_stage_control_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | id_ex_stage_control_unit                                                   |
// | Combinational opcode-to-control decoder and immediate extender.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module id_ex_stage_control_unit
    import mips_pkg::*;
#(
    parameter int LEN = 32
) (
    input  wire logic [5:0]     opcode,
    input  wire logic [15:0]    imm,
    output ctrl_t               ctrl,
    output logic [LEN-1:0]      imm_ext
);

    always_comb begin
        ctrl = CTRL_NOP;
        case (opcode)
            OP_RTYPE: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALUOP_RTYPE;
            end
            OP_LW: begin
                ctrl.alu_src    = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.alu_op     = ALUOP_ADD;
            end
            OP_SW: begin
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.alu_op    = ALUOP_ADD;
            end
            OP_BEQ: begin
                ctrl.branch = 1'b1;
                ctrl.alu_op = ALUOP_BRANCH;
            end
            OP_BNE: begin
                ctrl.branch_ne = 1'b1;
                ctrl.alu_op    = ALUOP_BRANCH;
            end
            // EX picks the actual operation from the registered opcode
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALUOP_IMM;
            end
            OP_J: begin
                ctrl.jump = 1'b1;
            end
            default: ctrl = CTRL_NOP;
        endcase
    end

    always_comb begin
        case (opcode)
            OP_ANDI, OP_ORI, OP_XORI: imm_ext = {{(LEN-16){1'b0}}, imm};
            OP_LUI:                   imm_ext = {imm, {(LEN-16){1'b0}}};
            default:                  imm_ext = {{(LEN-16){imm[15]}}, imm};
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | id_ex_stage                                                                |
// | Decode stage: ID/EX registers, load-use hazard detection, bubble insert.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int LEN      = 32,
    parameter int NB_ADDR  = 5,
    parameter int NB_ALUOP = 2
) (
    input  wire logic     i_clk,
    input  wire logic     i_rst,
    id_ex_stage_if.slave  bus
);

    logic [LEN-1:0]     instr;
    logic [NB_ADDR-1:0] dec_rs;
    logic [NB_ADDR-1:0] dec_rt;
    logic [NB_ADDR-1:0] dec_rd;
    ctrl_t              dec_ctrl;
    logic [LEN-1:0]     dec_imm;
    logic               stall;

    ctrl_t              ex_ctrl;
    logic [NB_ADDR-1:0] ex_rs;
    logic [NB_ADDR-1:0] ex_rt;
    logic [NB_ADDR-1:0] ex_rd;
    logic [LEN-1:0]     ex_imm;
    logic [4:0]         ex_shamt;
    logic [5:0]         ex_funct;
    logic [5:0]         ex_opcode;

    assign instr  = bus.i_instruction;
    assign dec_rs = NB_ADDR'(instr[RS_MSB:RS_LSB]);
    assign dec_rt = NB_ADDR'(instr[RT_MSB:RT_LSB]);
    assign dec_rd = NB_ADDR'(instr[RD_MSB:RD_LSB]);

    id_ex_stage_control_unit #(
        .LEN (LEN)
    ) u_control_unit (
        .opcode  (instr[OPCODE_MSB:OPCODE_LSB]),
        .imm     (instr[IMM_MSB:IMM_LSB]),
        .ctrl    (dec_ctrl),
        .imm_ext (dec_imm)
    );

    // rt is compared for every opcode, even ones that never read it
    assign stall = bus.i_enable & ex_ctrl.mem_read & (ex_rt != '0) &
                   ((ex_rt == dec_rs) | (ex_rt == dec_rt));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ex_ctrl   <= CTRL_NOP;
            ex_rs     <= '0;
            ex_rt     <= '0;
            ex_rd     <= '0;
            ex_imm    <= '0;
            ex_shamt  <= '0;
            ex_funct  <= '0;
            ex_opcode <= '0;
        end else if (bus.i_enable) begin
            ex_ctrl   <= (bus.i_flush | stall) ? CTRL_NOP : dec_ctrl;
            ex_rs     <= dec_rs;
            ex_rt     <= dec_rt;
            ex_rd     <= dec_rd;
            ex_imm    <= dec_imm;
            ex_shamt  <= instr[SHAMT_MSB:SHAMT_LSB];
            ex_funct  <= instr[FUNCT_MSB:FUNCT_LSB];
            ex_opcode <= instr[OPCODE_MSB:OPCODE_LSB];
        end
    end

    assign bus.o_stall    = stall;
    assign bus.o_rs       = ex_rs;
    assign bus.o_rt       = ex_rt;
    assign bus.o_rd       = ex_rd;
    assign bus.o_imm_ext  = ex_imm;
    assign bus.o_shamt    = ex_shamt;
    assign bus.o_funct    = ex_funct;
    assign bus.o_opcode   = ex_opcode;
    assign bus.o_RegDst   = ex_ctrl.reg_dst;
    assign bus.o_ALUSrc   = ex_ctrl.alu_src;
    assign bus.o_MemRead  = ex_ctrl.mem_read;
    assign bus.o_MemWrite = ex_ctrl.mem_write;
    assign bus.o_MemtoReg = ex_ctrl.mem_to_reg;
    assign bus.o_RegWrite = ex_ctrl.reg_write;
    assign bus.o_Branch   = ex_ctrl.branch;
    assign bus.o_BranchNE = ex_ctrl.branch_ne;
    assign bus.o_Jump     = ex_ctrl.jump;
    assign bus.o_ALUOp    = NB_ALUOP'(ex_ctrl.alu_op);

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_id_ex_stage                                                             |
// | Directed plus random stimulus against a behavioural decode-stage model.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_id_ex_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    id_ex_stage_if #(.LEN(32), .NB_ADDR(5), .NB_ALUOP(2)) bus ();

    id_ex_stage #(.LEN(32), .NB_ADDR(5), .NB_ALUOP(2)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Expected ID/EX contents; control packed as
    // {RegDst,ALUSrc,MemRead,MemWrite,MemtoReg,RegWrite,Branch,BranchNE,Jump,ALUOp[1:0]}
    logic [4:0]  m_rs, m_rt, m_rd, m_shamt;
    logic [31:0] m_imm;
    logic [5:0]  m_funct, m_op;
    logic [10:0] m_ctrl;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [10:0] ref_ctrl(input logic [5:0] op);
        case (op)
            6'b000000: return 11'b1_0_0_0_0_1_0_0_0_10;
            6'b100011: return 11'b0_1_1_0_1_1_0_0_0_00;
            6'b101011: return 11'b0_1_0_1_0_0_0_0_0_00;
            6'b000100: return 11'b0_0_0_0_0_0_1_0_0_01;
            6'b000101: return 11'b0_0_0_0_0_0_0_1_0_01;
            6'b001000, 6'b001010, 6'b001100,
            6'b001101, 6'b001110, 6'b001111:
                       return 11'b0_1_0_0_0_1_0_0_0_11;
            6'b000010: return 11'b0_0_0_0_0_0_0_0_1_00;
            default:   return 11'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_imm(input logic [5:0] op, input logic [15:0] imm);
        int v;
        if (op == 6'b001100 || op == 6'b001101 || op == 6'b001110)
            return 32'(imm);
        if (op == 6'b001111)
            return 32'(imm) * 32'd65536;
        v = (imm >= 16'h8000) ? int'(imm) - 65536 : int'(imm);
        return 32'(v);
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] funct);
        return {6'b000000, rs, rt, rd, 5'd0, funct};
    endfunction

    task automatic compare_all();
        check_eq("rs",     32'(bus.o_rs),      32'(m_rs));
        check_eq("rt",     32'(bus.o_rt),      32'(m_rt));
        check_eq("rd",     32'(bus.o_rd),      32'(m_rd));
        check_eq("imm",    bus.o_imm_ext,      m_imm);
        check_eq("shamt",  32'(bus.o_shamt),   32'(m_shamt));
        check_eq("funct",  32'(bus.o_funct),   32'(m_funct));
        check_eq("opcode", 32'(bus.o_opcode),  32'(m_op));
        check_eq("ctrl",   32'({bus.o_RegDst, bus.o_ALUSrc, bus.o_MemRead, bus.o_MemWrite,
                                bus.o_MemtoReg, bus.o_RegWrite, bus.o_Branch, bus.o_BranchNE,
                                bus.o_Jump, bus.o_ALUOp}), 32'(m_ctrl));
    endtask

    // One pipeline cycle: drive at negedge, check stall, clock, check registers
    task automatic step(input logic r, input logic en, input logic fl, input logic [31:0] ins);
        logic exp_stall;
        @(negedge clk);
        rst               = r;
        bus.i_enable      = en;
        bus.i_flush       = fl;
        bus.i_instruction = ins;
        #1;
        exp_stall = en && m_ctrl[8] && (m_rt != 5'd0) &&
                    (m_rt == ins[25:21] || m_rt == ins[20:16]);
        check_eq("stall", 32'(bus.o_stall), 32'(exp_stall));
        @(posedge clk);
        if (r) begin
            {m_rs, m_rt, m_rd, m_shamt, m_imm, m_funct, m_op, m_ctrl} = '0;
        end else if (en) begin
            m_rs    = ins[25:21];
            m_rt    = ins[20:16];
            m_rd    = ins[15:11];
            m_shamt = ins[10:6];
            m_funct = ins[5:0];
            m_op    = ins[31:26];
            m_imm   = ref_imm(ins[31:26], ins[15:0]);
            m_ctrl  = (fl || exp_stall) ? 11'b0 : ref_ctrl(ins[31:26]);
        end
        #1;
        compare_all();
    endtask

    logic [5:0] op_pool [13] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                                 6'b001000, 6'b001010, 6'b001100, 6'b001101, 6'b001110,
                                 6'b001111, 6'b000010, 6'b111111};

    logic [31:0] addi, lw2, add_dep, beq;

    initial begin
        {m_rs, m_rt, m_rd, m_shamt, m_imm, m_funct, m_op, m_ctrl} = '0;
        addi    = itype(6'b001000, 5'd1, 5'd2, 16'h0005);
        lw2     = itype(6'b100011, 5'd1, 5'd2, 16'hFFFC);
        add_dep = rtype(5'd2, 5'd4, 5'd3, 6'h20);
        beq     = itype(6'b000100, 5'd1, 5'd2, 16'h0010);
        bus.i_enable      = 1'b1;
        bus.i_flush       = 1'b0;
        bus.i_instruction = addi;
        @(posedge clk);

        // Reset held, then release onto ADDI
        step(1, 1, 0, addi);
        step(1, 1, 0, addi);
        step(0, 1, 0, addi);
        // Sign and zero extension
        step(0, 1, 0, lw2);
        step(0, 1, 0, itype(6'b001101, 5'd3, 5'd4, 16'h8000));
        step(0, 1, 0, itype(6'b001111, 5'd0, 5'd5, 16'h8001));
        // Load-use: bubble then ADD
        step(0, 1, 0, lw2);
        step(0, 1, 0, add_dep);
        step(0, 1, 0, add_dep);
        // Load into $0 never stalls
        step(0, 1, 0, itype(6'b100011, 5'd1, 5'd0, 16'h0004));
        step(0, 1, 0, rtype(5'd0, 5'd4, 5'd3, 6'h20));
        // Flush, and flush coinciding with stall
        step(0, 1, 1, beq);
        step(0, 1, 0, lw2);
        step(0, 1, 1, add_dep);
        step(0, 1, 0, add_dep);
        // Enable low freezes everything while the instruction changes
        step(0, 1, 0, lw2);
        step(0, 0, 0, add_dep);
        step(0, 0, 0, beq);
        step(0, 0, 0, addi);
        step(0, 1, 0, add_dep);
        step(0, 1, 0, add_dep);
        // Undefined opcode and reset during stall
        step(0, 1, 0, {6'b111111, 26'h2AB_CDEF});
        step(0, 1, 0, lw2);
        step(1, 1, 0, add_dep);
        step(0, 1, 0, add_dep);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] ins;
            ins = $urandom;
            ins[31:26] = op_pool[$urandom_range(0, 12)];
            ins[25:21] = 5'($urandom_range(0, 3));
            ins[20:16] = 5'($urandom_range(0, 3));
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 7) == 0), ins);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
